snake_draw_engine: RTL and testbench

Parametrised successor to the single-command snake drawing slave. It accepts HPS draw commands over an Avalon-MM slave and queues them in a command FIFO. Each command is rendered as a CELL×CELL pixel block, or a full-grid clear, into the VGA pixel buffer through an Avalon-MM master that honours waitrequest. It sits between the HPS lightweight bridge and the VGA pixel-buffer port.

---
 rtl/snake_draw_engine.sv | 189 ++++++++++++++++++
 tb/tb_snake_draw_engine.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_draw_engine.sv
// rtl/snake_draw_engine.sv - queued Avalon-MM draw engine rendering snake cells into a VGA pixel buffer
module snake_draw_engine #(
    parameter int unsigned CELL        = 4,
    parameter int unsigned GRID_W      = 80,
    parameter int unsigned GRID_H      = 60,
    parameter int unsigned DEPTH       = 8,
    parameter logic [31:0] PX_BASE     = 32'h0800_0000,
    parameter logic [15:0] SNAKE_COLOR = 16'h07E0,
    parameter logic [15:0] FOOD_COLOR  = 16'hF800,
    parameter logic [15:0] BG_COLOR    = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  hps_address,
    input  logic        hps_read,
    output logic [31:0] hps_readdata,
    input  logic        hps_write,
    input  logic [31:0] hps_writedata,
    output logic        hps_waitrequest,
    output logic [31:0] vga_px_address,
    output logic        vga_px_write,
    output logic [15:0] vga_px_writedata,
    input  logic        vga_px_waitrequest
);
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [8:0]  CELL9    = 9'(CELL);
    localparam logic [8:0]  CLR_W    = 9'(GRID_W * CELL);
    localparam logic [8:0]  CLR_H    = 9'(GRID_H * CELL);
    localparam logic [8:0]  GW9      = 9'(GRID_W);
    localparam logic [7:0]  GH8      = 8'(GRID_H);

    typedef enum logic [1:0] {IDLE, DECODE, DRAW} state_t;

    // FIFO entry layout: {cmd[3:0], x[8:0], y[7:0]}
    logic [20:0]   fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q, range_err_q;

    state_t        state_q;
    logic [20:0]   cmd_q;
    logic [8:0]    ox_q, oy_q, i_q, j_q, w_lim_q, h_lim_q;
    logic          px_write_q;
    logic [31:0]   px_addr_q;
    logic [15:0]   px_data_q;

    logic cmd_wr, fifo_full, fifo_pop, fifo_push, ovf_set, rerr_set, sticky_clr, busy;
    logic [3:0]  cmd_code;
    logic [8:0]  cmd_x;
    logic [7:0]  cmd_y;
    logic        cmd_valid_d;
    logic [15:0] color_d;
    logic [8:0]  org_x_d, org_y_d, w_lim_d, h_lim_d;

    function automatic logic [31:0] pix_addr(input logic [8:0] px, input logic [8:0] py);
        return PX_BASE + {13'b0, py, 10'b0} + {22'b0, px, 1'b0};
    endfunction

    assign cmd_wr     = hps_write && (hps_address == 4'd0);
    assign sticky_clr = hps_write && (hps_address == 4'd1) && hps_writedata[0];
    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_pop   = (state_q == IDLE) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign fifo_push  = cmd_wr && (!fifo_full || fifo_pop);
    assign ovf_set    = cmd_wr && fifo_full && !fifo_pop;
    assign busy       = (state_q != IDLE) || (count_q != '0);

    assign cmd_code = cmd_q[20:17];
    assign cmd_x    = cmd_q[16:8];
    assign cmd_y    = cmd_q[7:0];
    assign rerr_set = (state_q == DECODE) && !cmd_valid_d;

    always_comb begin
        cmd_valid_d = 1'b0;
        color_d     = BG_COLOR;
        org_x_d     = 9'(cmd_x * CELL);
        org_y_d     = 9'(cmd_y * CELL);
        w_lim_d     = CELL9;
        h_lim_d     = CELL9;
        case (cmd_code)
            4'd1: begin cmd_valid_d = (cmd_x < GW9) && (cmd_y < GH8); color_d = SNAKE_COLOR; end
            4'd2: begin cmd_valid_d = (cmd_x < GW9) && (cmd_y < GH8); color_d = BG_COLOR;    end
            4'd3: begin cmd_valid_d = (cmd_x < GW9) && (cmd_y < GH8); color_d = FOOD_COLOR;  end
            4'd4: begin
                cmd_valid_d = 1'b1;
                org_x_d     = '0;
                org_y_d     = '0;
                w_lim_d     = CLR_W;
                h_lim_d     = CLR_H;
            end
            default: cmd_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_q[wr_ptr_q] <= {hps_writedata[31:28], hps_writedata[24:16], hps_writedata[15:8]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            range_err_q <= 1'b0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({fifo_push, fifo_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            overflow_q  <= ovf_set  | (overflow_q  & ~sticky_clr);
            range_err_q <= rerr_set | (range_err_q & ~sticky_clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            i_q        <= '0;
            j_q        <= '0;
            w_lim_q    <= '0;
            h_lim_q    <= '0;
            px_write_q <= 1'b0;
            px_addr_q  <= '0;
            px_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (fifo_pop) begin
                    cmd_q   <= fifo_q[rd_ptr_q];
                    state_q <= DECODE;
                end
                DECODE: begin
                    i_q <= '0;
                    j_q <= '0;
                    if (cmd_valid_d) begin
                        ox_q       <= org_x_d;
                        oy_q       <= org_y_d;
                        w_lim_q    <= w_lim_d;
                        h_lim_q    <= h_lim_d;
                        px_data_q  <= color_d;
                        px_addr_q  <= pix_addr(org_x_d, org_y_d);
                        px_write_q <= 1'b1;
                        state_q    <= DRAW;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAW: if (!vga_px_waitrequest) begin
                    if (i_q == w_lim_q - 9'd1) begin
                        if (j_q == h_lim_q - 9'd1) begin
                            px_write_q <= 1'b0;
                            state_q    <= IDLE;
                        end else begin
                            i_q       <= '0;
                            j_q       <= j_q + 9'd1;
                            px_addr_q <= pix_addr(ox_q, oy_q + j_q + 9'd1);
                        end
                    end else begin
                        i_q       <= i_q + 9'd1;
                        px_addr_q <= pix_addr(ox_q + i_q + 9'd1, oy_q + j_q);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        hps_readdata = '0;
        if (hps_read && (hps_address == 4'd1))
            hps_readdata = {21'b0, range_err_q, overflow_q, busy, 8'(count_q)};
    end

    logic unused_wdata;
    assign unused_wdata = &{1'b0, hps_writedata[27:25], hps_writedata[7:1]};

    assign hps_waitrequest  = 1'b0;
    assign vga_px_write     = px_write_q;
    assign vga_px_address   = px_addr_q;
    assign vga_px_writedata = px_data_q;
endmodule

// File: tb/tb_snake_draw_engine.sv
// tb/tb_snake_draw_engine.sv - scoreboard bench for the snake_draw_engine pixel stream and status register
module tb_snake_draw_engine;
    localparam logic [31:0] PX_BASE = 32'h0800_0000;
    localparam logic [15:0] GREEN   = 16'h07E0;
    localparam logic [15:0] RED     = 16'hF800;
    localparam logic [15:0] BLACK   = 16'h0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  hps_address = '0;
    logic        hps_read = 1'b0;
    logic [31:0] hps_readdata;
    logic        hps_write = 1'b0;
    logic [31:0] hps_writedata = '0;
    logic        hps_waitrequest;
    logic [31:0] vga_px_address;
    logic        vga_px_write;
    logic [15:0] vga_px_writedata;
    logic        vga_px_waitrequest = 1'b0;

    snake_draw_engine dut (
        .clk(clk), .reset_n(reset_n),
        .hps_address(hps_address), .hps_read(hps_read), .hps_readdata(hps_readdata),
        .hps_write(hps_write), .hps_writedata(hps_writedata), .hps_waitrequest(hps_waitrequest),
        .vga_px_address(vga_px_address), .vga_px_write(vga_px_write),
        .vga_px_writedata(vga_px_writedata), .vga_px_waitrequest(vga_px_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] data;
    } px_t;

    px_t         sb[$];
    px_t         exp_px;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] paddr(input int px, input int py);
        return PX_BASE + 32'(py << 10) + 32'(px << 1);
    endfunction

    function automatic logic [31:0] cmdw(input int c, input int x, input int y);
        return {c[3:0], 3'b000, x[8:0], y[7:0], 8'h00};
    endfunction

    task automatic exp_cell(input int x, input int y, input logic [15:0] col);
        for (int j = 0; j < 4; j++)
            for (int i = 0; i < 4; i++)
                sb.push_back(px_t'{paddr(x*4 + i, y*4 + j), col});
    endtask

    // Monitor: every accepted pixel is popped from the scoreboard; stalled pixels must stay put.
    always @(negedge clk) begin
        if (vga_px_write && prev_stall) begin
            check("hold_addr", vga_px_address, prev_addr);
            check("hold_data", {16'h0, vga_px_writedata}, {16'h0, prev_data});
        end
        prev_stall = vga_px_write && vga_px_waitrequest;
        prev_addr  = vga_px_address;
        prev_data  = vga_px_writedata;
        if (vga_px_write) begin
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
        end
        if (vga_px_write && !vga_px_waitrequest) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%04h expected no write",
                         vga_px_address, vga_px_writedata);
            end else begin
                exp_px = sb.pop_front();
                check("px_addr", vga_px_address, exp_px.addr);
                check("px_data", {16'h0, vga_px_writedata}, {16'h0, exp_px.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hps_wr(input logic [3:0] a, input logic [31:0] d);
        hps_address   = a;
        hps_writedata = d;
        hps_write     = 1'b1;
        @(posedge clk);
        #1;
        hps_write   = 1'b0;
        hps_address = '0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        hps_address = 4'd1;
        hps_read    = 1'b1;
        #1;
        v           = hps_readdata;
        hps_read    = 1'b0;
        hps_address = '0;
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] s;
        int n;
        n = 0;
        do begin
            tick();
            rd_status(s);
            n++;
        end while (s[8] && n < budget);
        check("busy_after_drain", {31'b0, s[8]}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int t0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_write", {31'b0, vga_px_write}, 32'd0);
        check("rst_addr", vga_px_address, 32'd0);
        check("rst_data", {16'h0, vga_px_writedata}, 32'd0);
        reset_n = 1'b1;
        tick();
        rd_status(s);
        check("rst_status", s, 32'd0);

        // Single ADD: latency and cell footprint
        tick();
        first_cyc = -1;
        exp_cell(1, 1, GREEN);
        t0 = cyc;
        hps_wr(4'd0, cmdw(1, 1, 1));
        wait_idle(100);
        check("add_latency", 32'(first_cyc - t0), 32'd3);
        check("add_span", 32'(last_cyc - first_cyc + 1), 32'd16);
        check("add_drained", 32'(sb.size()), 32'd0);

        // Back-to-back ADD then DEL: 16 + 2 gap + 16
        tick();
        first_cyc = -1;
        exp_cell(1, 1, GREEN);
        exp_cell(10, 10, BLACK);
        hps_wr(4'd0, cmdw(1, 1, 1));
        hps_wr(4'd0, cmdw(2, 10, 10));
        rd_status(s);
        check("b2b_busy", {31'b0, s[8]}, 32'd1);
        wait_idle(200);
        check("b2b_span", 32'(last_cyc - first_cyc + 1), 32'd34);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Five-cycle stall mid-cell
        tick();
        first_cyc = -1;
        exp_cell(2, 3, GREEN);
        hps_wr(4'd0, cmdw(1, 2, 3));
        repeat (7) tick();
        vga_px_waitrequest = 1'b1;
        repeat (5) tick();
        vga_px_waitrequest = 1'b0;
        wait_idle(100);
        check("stall_span", 32'(last_cyc - first_cyc + 1), 32'd21);
        check("stall_drained", 32'(sb.size()), 32'd0);

        // Overflow: blocker stalled in DRAW, then DEPTH+2 commands
        tick();
        vga_px_waitrequest = 1'b1;
        exp_cell(0, 2, GREEN);
        hps_wr(4'd0, cmdw(1, 0, 2));
        repeat (3) tick();
        for (int k = 0; k < 10; k++) begin
            if (k < 8) exp_cell(k, 5, RED);
            hps_wr(4'd0, cmdw(3, k, 5));
        end
        rd_status(s);
        check("ovf_count", {24'b0, s[7:0]}, 32'd8);
        check("ovf_flag", {31'b0, s[9]}, 32'd1);
        check("ovf_range_clear", {31'b0, s[10]}, 32'd0);
        vga_px_waitrequest = 1'b0;
        wait_idle(400);
        check("ovf_drained", 32'(sb.size()), 32'd0);
        hps_wr(4'd1, 32'd1);
        rd_status(s);
        check("ovf_cleared", {31'b0, s[9]}, 32'd0);

        // Invalid commands are discarded, boundary cell still drawn
        tick();
        hps_wr(4'd0, cmdw(1, 80, 0));
        hps_wr(4'd0, cmdw(2, 0, 60));
        hps_wr(4'd0, cmdw(7, 1, 1));
        wait_idle(50);
        rd_status(s);
        check("range_err_set", {31'b0, s[10]}, 32'd1);
        check("range_no_ovf", {31'b0, s[9]}, 32'd0);
        tick();
        exp_cell(79, 59, RED);
        hps_wr(4'd0, cmdw(3, 79, 59));
        wait_idle(100);
        check("edge_drained", 32'(sb.size()), 32'd0);
        hps_wr(4'd1, 32'd1);
        rd_status(s);
        check("range_err_cleared", {31'b0, s[10]}, 32'd0);

        // CLEAR sweeps rows of 320; reset lands after exactly 700 pixels
        tick();
        for (int p = 0; p < 1000; p++) sb.push_back(px_t'{paddr(p % 320, p / 320), BLACK});
        hps_wr(4'd0, cmdw(4, 5, 5));
        repeat (702) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_write", {31'b0, vga_px_write}, 32'd0);
        check("async_rst_addr", vga_px_address, 32'd0);
        check("clear_progress", 32'(sb.size()), 32'd300);
        sb.delete();
        tick();
        rd_status(s);
        check("rst_mid_status", s, 32'd0);
        reset_n = 1'b1;
        tick();
        exp_cell(0, 0, GREEN);
        hps_wr(4'd0, cmdw(1, 0, 0));
        wait_idle(100);
        check("post_rst_drained", 32'(sb.size()), 32'd0);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
